mips_debug_ctrl: RTL and testbench

MIPS_DEBUG_CTRL -- requirements
Module: mips_debug_ctrl

---
 rtl/mips_debug_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mips_debug_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_debug_ctrl.sv
// Host-side debug controller for a MIPS core: loads instruction memory from a
// byte stream, runs or single-steps the CPU, and dumps a snapshot frame back.
module mips_debug_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int N_REGS  = 8,
  parameter int N_LATCH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rx_valid,
  input  logic [7:0]                  rx_data,
  output logic                        rx_ready,
  output logic                        tx_valid,
  output logic [7:0]                  tx_data,
  input  logic                        tx_ready,
  output logic                        cpu_en,
  output logic                        wea_ram_inst,
  output logic [ADDR_W-1:0]           in_addr_mem_inst,
  output logic [DATA_W-1:0]           in_ins_to_mem,
  input  logic [DATA_W-1:0]           pc_in,
  input  logic [DATA_W-1:0]           mem_in,
  input  logic                        halt_flag,
  input  logic [N_REGS*DATA_W-1:0]    regs_in,
  input  logic [N_LATCH*DATA_W-1:0]   latches_in,
  output logic                        busy
);

  localparam int WORD_BYTES  = DATA_W / 8;
  localparam int N_WORDS     = N_REGS + N_LATCH + 2;
  localparam int FRAME_W     = N_WORDS * DATA_W;
  localparam int FRAME_BYTES = N_WORDS * WORD_BYTES;
  localparam int IDX_W       = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int BCNT_W      = $clog2(FRAME_BYTES);

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_DUMP = 8'h44;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_CNT,
    LOAD_WORD,
    WRITE,
    RUN,
    STEP,
    DUMP
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [7:0]          word_cnt;
  logic [IDX_W-1:0]    byte_idx;
  logic [FRAME_W-1:0]  frame;
  logic [FRAME_W-1:0]  snap;
  logic [BCNT_W-1:0]   byte_cnt;
  logic                dump_entry;
  logic                last_byte_in_word;

  assign last_byte_in_word = (byte_idx == IDX_W'(WORD_BYTES - 1));
  assign dump_entry        = (next_state == DUMP) && (state != DUMP);
  assign tx_data           = frame[FRAME_W-1 -: 8];

  // Frame layout from the MSB end: pc, reg0.., latch0.., mem.
  always_comb begin
    snap = '0;
    snap[FRAME_W-1 -: DATA_W] = pc_in;
    for (int i = 0; i < N_REGS; i++)
      snap[(N_WORDS-2-i)*DATA_W +: DATA_W] = regs_in[i*DATA_W +: DATA_W];
    for (int j = 0; j < N_LATCH; j++)
      snap[(N_WORDS-2-N_REGS-j)*DATA_W +: DATA_W] = latches_in[j*DATA_W +: DATA_W];
    snap[DATA_W-1:0] = mem_in;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = state;
    rx_ready     = 1'b0;
    cpu_en       = 1'b0;
    wea_ram_inst = 1'b0;
    tx_valid     = 1'b0;
    busy         = 1'b1;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        rx_ready = 1'b1;
        if (rx_valid) begin
          case (rx_data)
            CMD_LOAD: next_state = LOAD_CNT;
            CMD_RUN:  next_state = RUN;
            CMD_STEP: next_state = STEP;
            CMD_DUMP: next_state = DUMP;
            default:  next_state = IDLE;
          endcase
        end
      end
      LOAD_CNT: begin
        rx_ready = 1'b1;
        if (rx_valid) next_state = (rx_data == 8'd0) ? IDLE : LOAD_WORD;
      end
      LOAD_WORD: begin
        rx_ready = 1'b1;
        if (rx_valid && last_byte_in_word) next_state = WRITE;
      end
      WRITE: begin
        wea_ram_inst = 1'b1;
        next_state   = (word_cnt == 8'd1) ? IDLE : LOAD_WORD;
      end
      // The halt cycle itself never enables the CPU, so an already-halted core
      // sees zero enable cycles.
      RUN: begin
        if (halt_flag) next_state = DUMP;
        else           cpu_en     = 1'b1;
      end
      STEP: begin
        cpu_en     = 1'b1;
        next_state = DUMP;
      end
      DUMP: begin
        tx_valid = 1'b1;
        if (tx_ready && byte_cnt == BCNT_W'(FRAME_BYTES - 1)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_addr_mem_inst <= '0;
      in_ins_to_mem    <= '0;
      word_cnt         <= '0;
      byte_idx         <= '0;
      frame            <= '0;
      byte_cnt         <= '0;
    end else begin
      if (state == IDLE && rx_valid && rx_data == CMD_LOAD)
        in_addr_mem_inst <= '0;
      if (state == LOAD_CNT && rx_valid) begin
        word_cnt <= rx_data;
        byte_idx <= '0;
      end
      if (state == LOAD_WORD && rx_valid) begin
        in_ins_to_mem <= (in_ins_to_mem << 8) | DATA_W'(rx_data);
        byte_idx      <= last_byte_in_word ? '0 : byte_idx + 1'b1;
      end
      if (state == WRITE) begin
        in_addr_mem_inst <= in_addr_mem_inst + 1'b1;
        word_cnt         <= word_cnt - 8'd1;
      end
      // The frame register only moves on a transfer, which keeps tx_data stable under backpressure.
      if (dump_entry) begin
        frame    <= snap;
        byte_cnt <= '0;
      end else if (state == DUMP && tx_ready) begin
        frame    <= frame << 8;
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Directed bench for mips_debug_ctrl: table-driven load/command vectors plus
// hand-written run, step, dump, backpressure and mid-operation reset sequences.
module tb_mips_debug_ctrl;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int N_REGS  = 8;
  localparam int N_LATCH = 4;
  localparam int FRAME_BYTES = (N_REGS + N_LATCH + 2) * DATA_W / 8;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic                       rx_valid = 1'b0;
  logic [7:0]                 rx_data = 8'h00;
  logic                       rx_ready;
  logic                       tx_valid;
  logic [7:0]                 tx_data;
  logic                       tx_ready = 1'b1;
  logic                       cpu_en;
  logic                       wea_ram_inst;
  logic [ADDR_W-1:0]          in_addr_mem_inst;
  logic [DATA_W-1:0]          in_ins_to_mem;
  logic [DATA_W-1:0]          pc_in = '0;
  logic [DATA_W-1:0]          mem_in = '0;
  logic                       halt_flag = 1'b0;
  logic [N_REGS*DATA_W-1:0]   regs_in = '0;
  logic [N_LATCH*DATA_W-1:0]  latches_in = '0;
  logic                       busy;

  mips_debug_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_REGS(N_REGS), .N_LATCH(N_LATCH)
  ) dut (
    .clk(clk), .reset(reset),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .cpu_en(cpu_en),
    .wea_ram_inst(wea_ram_inst), .in_addr_mem_inst(in_addr_mem_inst),
    .in_ins_to_mem(in_ins_to_mem),
    .pc_in(pc_in), .mem_in(mem_in), .halt_flag(halt_flag),
    .regs_in(regs_in), .latches_in(latches_in), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] in_byte;
    logic       exp_busy;
    logic       exp_rx_ready;
    logic       exp_wea;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cpu_cnt = 0;
  int          cycles;
  int          n_hold;
  logic [7:0]  tx_q [$];
  wr_t         wr_q [$];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  logic [DATA_W-1:0] model_pc;
  logic [DATA_W-1:0] model_mem;
  logic [DATA_W-1:0] model_regs [N_REGS];
  logic [DATA_W-1:0] model_latches [N_LATCH];

  vec_t vecs [16];

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Holds rx_valid until the byte is accepted; returns just after the accepting edge.
  task automatic apply_stimulus(input logic [7:0] b);
    bit done = 1'b0;
    bit ok;
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      ok = rx_ready;
      @(posedge clk); #1;
      if (ok) done = 1'b1;
    end
    rx_valid = 1'b0;
    check_output($sformatf("rx_accept_%02h", b), 64'(done), 64'd1);
  endtask

  task automatic drive_model_inputs();
    pc_in  = model_pc;
    mem_in = model_mem;
    for (int i = 0; i < N_REGS; i++)  regs_in[i*DATA_W +: DATA_W]    = model_regs[i];
    for (int j = 0; j < N_LATCH; j++) latches_in[j*DATA_W +: DATA_W] = model_latches[j];
  endtask

  task automatic wait_frame(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (!busy && tx_q.size() > 0) done = 1'b1;
    end
    check_output({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic check_frame(input string tag);
    logic [DATA_W-1:0] w [N_REGS+N_LATCH+2];
    logic [7:0] b;
    int idx;
    check_output({tag, "_len"}, 64'(tx_q.size()), 64'(FRAME_BYTES));
    w[0] = model_pc;
    for (int i = 0; i < N_REGS; i++)  w[1+i] = model_regs[i];
    for (int j = 0; j < N_LATCH; j++) w[1+N_REGS+j] = model_latches[j];
    w[N_REGS+N_LATCH+1] = model_mem;
    for (int k = 0; k < N_REGS+N_LATCH+2; k++) begin
      for (int n = 0; n < 4; n++) begin
        b   = w[k][31-8*n -: 8];
        idx = k*4 + n;
        if (idx < tx_q.size())
          check_output($sformatf("%s_byte%0d", tag, idx), 64'(tx_q[idx]), 64'(b));
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (wea_ram_inst) wr_q.push_back('{in_addr_mem_inst, in_ins_to_mem});
      if (cpu_en) cpu_cnt++;
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
      if (prev_stall && tx_valid) check_output("tx_hold", 64'(tx_data), 64'(prev_data));
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{8'h4C, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{8'h00, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{8'h4C, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{8'h02, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{8'h11, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{8'hAA, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{8'hBB, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{8'hCC, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{8'hDD, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{8'h4C, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{8'h00, 1'b0, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_output("rst_busy",     64'(busy), 64'd0);
    check_output("rst_rx_ready", 64'(rx_ready), 64'd1);
    check_output("rst_cpu_en",   64'(cpu_en), 64'd0);
    check_output("rst_wea",      64'(wea_ram_inst), 64'd0);
    check_output("rst_tx_valid", 64'(tx_valid), 64'd0);
    check_output("rst_tx_data",  64'(tx_data), 64'd0);
    check_output("rst_addr",     64'(in_addr_mem_inst), 64'd0);
    check_output("rst_ins",      64'(in_ins_to_mem), 64'd0);

    for (int v = 0; v < 16; v++) begin
      apply_stimulus(vecs[v].in_byte);
      @(negedge clk);
      check_output($sformatf("vec%0d_busy", v),     64'(busy), 64'(vecs[v].exp_busy));
      check_output($sformatf("vec%0d_rx_ready", v), 64'(rx_ready), 64'(vecs[v].exp_rx_ready));
      check_output($sformatf("vec%0d_wea", v),      64'(wea_ram_inst), 64'(vecs[v].exp_wea));
    end
    repeat (3) @(negedge clk);
    check_output("load_nwrites", 64'(wr_q.size()), 64'd2);
    if (wr_q.size() == 2) begin
      check_output("load_w0_addr", 64'(wr_q[0].addr), 64'd0);
      check_output("load_w0_data", 64'(wr_q[0].data), 64'h0000_0011);
      check_output("load_w1_addr", 64'(wr_q[1].addr), 64'd1);
      check_output("load_w1_data", 64'(wr_q[1].data), 64'hAABB_CCDD);
    end
    check_output("idle_no_cpu_en", 64'(cpu_cnt), 64'd0);
    check_output("idle_no_tx",     64'(tx_q.size()), 64'd0);
    check_output("load_end_busy",  64'(busy), 64'd0);

    // Step with only pc_in set.
    model_pc = 32'h0000_0004;
    model_mem = '0;
    for (int i = 0; i < N_REGS; i++)  model_regs[i] = '0;
    for (int j = 0; j < N_LATCH; j++) model_latches[j] = '0;
    drive_model_inputs();
    cpu_cnt = 0;
    tx_q.delete();
    apply_stimulus(8'h53);
    wait_frame("step");
    check_output("step_cpu_cycles", 64'(cpu_cnt), 64'd1);
    check_frame("step");

    // Run, halt raised 10 cycles after the command is taken.
    model_pc  = 32'h0040_0010;
    model_mem = 32'hCAFE_F00D;
    for (int i = 0; i < N_REGS; i++)  model_regs[i] = 32'h1000_0000 + 32'(i * 17);
    for (int j = 0; j < N_LATCH; j++) model_latches[j] = 32'hA0A0_0000 + 32'(j);
    drive_model_inputs();
    cpu_cnt = 0;
    tx_q.delete();
    apply_stimulus(8'h43);
    repeat (10) @(posedge clk);
    #1 halt_flag = 1'b1;
    wait_frame("run");
    check_output("run_cpu_cycles", 64'(cpu_cnt), 64'd10);
    check_frame("run");

    cpu_cnt = 0;
    tx_q.delete();
    apply_stimulus(8'h43);
    wait_frame("run_halted");
    check_output("run_halted_cpu_cycles", 64'(cpu_cnt), 64'd0);
    check_frame("run_halted");
    halt_flag = 1'b0;

    // Reset in the middle of a run.
    cpu_cnt = 0;
    apply_stimulus(8'h43);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    cpu_cnt = 0;
    repeat (5) @(negedge clk);
    check_output("run_rst_cpu_cycles", 64'(cpu_cnt), 64'd0);
    check_output("run_rst_busy", 64'(busy), 64'd0);

    // Reset in the middle of a dump.
    tx_q.delete();
    apply_stimulus(8'h44);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    n_hold = tx_q.size();
    repeat (5) @(negedge clk);
    check_output("dump_rst_tx_valid", 64'(tx_valid), 64'd0);
    check_output("dump_rst_no_more",  64'(tx_q.size()), 64'(n_hold));
    check_output("dump_rst_busy",     64'(busy), 64'd0);

    // Backpressure, with inputs changed after the snapshot.
    model_pc  = 32'h1234_5678;
    model_mem = 32'h0BAD_BEEF;
    for (int i = 0; i < N_REGS; i++)  model_regs[i] = 32'h0101_0101 * 32'(i + 1);
    for (int j = 0; j < N_LATCH; j++) model_latches[j] = 32'hF000_000F ^ 32'(j << 8);
    drive_model_inputs();
    tx_q.delete();
    tx_ready = 1'b1;
    apply_stimulus(8'h44);
    cycles = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!tx_valid) break;
      cycles++;
      @(posedge clk); #1;
      tx_ready = ~tx_ready;
      if (cycles == 1) begin
        pc_in = 32'hFFFF_FFFF;
        mem_in = 32'h5555_5555;
        regs_in = '1;
        latches_in = '1;
      end
    end
    tx_ready = 1'b1;
    check_output("bp_cycles", 64'(cycles), 64'd111);
    check_frame("bp");
    @(negedge clk);
    check_output("bp_end_busy", 64'(busy), 64'd0);

    // Reset after the 5th byte of a load, then a clean single-word load.
    wr_q.delete();
    apply_stimulus(8'h4C);
    apply_stimulus(8'h02);
    apply_stimulus(8'h00);
    apply_stimulus(8'h00);
    apply_stimulus(8'h00);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_output("ld_rst_busy",     64'(busy), 64'd0);
    check_output("ld_rst_rx_ready", 64'(rx_ready), 64'd1);
    repeat (3) @(negedge clk);
    check_output("ld_rst_nwrites", 64'(wr_q.size()), 64'd0);
    apply_stimulus(8'h4C);
    apply_stimulus(8'h01);
    apply_stimulus(8'hDE);
    apply_stimulus(8'hAD);
    apply_stimulus(8'hBE);
    apply_stimulus(8'hEF);
    repeat (3) @(negedge clk);
    check_output("ld2_nwrites", 64'(wr_q.size()), 64'd1);
    if (wr_q.size() == 1) begin
      check_output("ld2_addr", 64'(wr_q[0].addr), 64'd0);
      check_output("ld2_data", 64'(wr_q[0].data), 64'hDEAD_BEEF);
    end
    check_output("ld2_busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
